// File: rtl/sme_pkg.sv
// Shared constants and state encoding for the SME job feeder.
package sme_pkg;

  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_TAG_S  = 8'h53;
  localparam logic [7:0] CH_TAG_P  = 8'h50;
  localparam logic [7:0] CH_HAT    = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;

  localparam int STR_MAX_DEF  = 32;
  localparam int PAT_MAX_DEF  = 10;
  localparam int WAIT_MAX_DEF = 1023;

  typedef enum logic [3:0] {
    ST_TAG,
    ST_RX_STR,
    ST_RX_PAT,
    ST_SKIP,
    ST_EMIT_STR,
    ST_EMIT_PAT,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/sme_line_buf.sv
// Byte line buffer: saturating write count with overflow flag, plus a sequential read pointer for replay.
import sme_pkg::*;

module sme_line_buf #(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [7:0]       i_wdata,
  input  logic             i_rd_rst,
  input  logic             i_rd_adv,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf,
  output logic [7:0]       o_rdata,
  output logic             o_rd_last
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rd;
  logic             r_ovf;
  logic             w_room;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;

  assign w_room  = r_cnt < CNT_W'(DEPTH);
  assign w_waddr = r_cnt[AW-1:0];
  assign w_raddr = r_rd[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_rd  <= '0;
    end else begin
      if (i_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (i_wr) begin
        if (w_room) r_cnt <= r_cnt + 1'b1;
        else        r_ovf <= 1'b1;
      end
      if (i_rd_rst)
        r_rd <= '0;
      else if (i_rd_adv && r_rd < CNT_W'(DEPTH))
        r_rd <= r_rd + 1'b1;
    end
  end

  // Storage carries no reset; only the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (i_wr && !i_clr && w_room)
      r_mem[w_waddr] <= i_wdata;
  end

  assign o_cnt     = r_cnt;
  assign o_ovf     = r_ovf;
  assign o_rdata   = (r_rd < CNT_W'(DEPTH)) ? r_mem[w_raddr] : 8'h00;
  assign o_rd_last = (r_rd == r_cnt - 1'b1);

endmodule

// File: rtl/sme_job_feeder.sv
// Collects tagged string/pattern lines, replays them to the SME as contiguous bursts,
// launches the match and returns the SME result (or a local rejection) on a valid/ready port.
import sme_pkg::*;

module sme_job_feeder #(
  parameter int STR_MAX  = STR_MAX_DEF,
  parameter int PAT_MAX  = PAT_MAX_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err
);

  localparam int STR_CW = $clog2(STR_MAX + 1);
  localparam int PAT_CW = $clog2(PAT_MAX + 1);
  localparam int WD_W   = 10;

  state_t            r_state;
  logic              r_in_ready;
  logic [7:0]        r_chardata;
  logic              r_isstring;
  logic              r_ispattern;
  logic              r_res_valid;
  logic              r_res_match;
  logic [4:0]        r_res_index;
  logic              r_res_err;
  logic              r_str_ok;
  logic [WD_W-1:0]   r_wdog;

  logic              w_acc;
  logic              w_is_lf;
  logic              w_str_clr, w_str_wr, w_str_ovf, w_str_last;
  logic              w_pat_clr, w_pat_wr, w_pat_ovf, w_pat_last;
  logic [STR_CW-1:0] w_str_cnt;
  logic [PAT_CW-1:0] w_pat_cnt;
  logic [7:0]        w_str_rdata, w_pat_rdata;

  assign w_acc     = in_valid && r_in_ready;
  assign w_is_lf   = (in_data == CH_LF);
  assign w_str_clr = w_acc && (r_state == ST_TAG) && (in_data == CH_TAG_S);
  assign w_pat_clr = w_acc && (r_state == ST_TAG) && (in_data == CH_TAG_P);
  assign w_str_wr  = w_acc && (r_state == ST_RX_STR) && !w_is_lf;
  assign w_pat_wr  = w_acc && (r_state == ST_RX_PAT) && !w_is_lf;

  sme_line_buf #(.DEPTH(STR_MAX), .CNT_W(STR_CW)) u_str_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_clr     (w_str_clr),
    .i_wr      (w_str_wr),
    .i_wdata   (in_data),
    .i_rd_rst  (r_state != ST_EMIT_STR),
    .i_rd_adv  (r_state == ST_EMIT_STR),
    .o_cnt     (w_str_cnt),
    .o_ovf     (w_str_ovf),
    .o_rdata   (w_str_rdata),
    .o_rd_last (w_str_last)
  );

  sme_line_buf #(.DEPTH(PAT_MAX), .CNT_W(PAT_CW)) u_pat_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_clr     (w_pat_clr),
    .i_wr      (w_pat_wr),
    .i_wdata   (in_data),
    .i_rd_rst  (r_state != ST_EMIT_PAT),
    .i_rd_adv  (r_state == ST_EMIT_PAT),
    .o_cnt     (w_pat_cnt),
    .o_ovf     (w_pat_ovf),
    .o_rdata   (w_pat_rdata),
    .o_rd_last (w_pat_last)
  );

  // SME drive is registered, so it trails the EMIT states by one cycle and the
  // idle launch cycle becomes visible on the first WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_TAG;
      r_in_ready  <= 1'b0;
      r_chardata  <= 8'h00;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= 5'd0;
      r_res_err   <= 1'b0;
      r_str_ok    <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_chardata  <= 8'h00;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      case (r_state)
        ST_TAG: begin
          r_in_ready <= 1'b1;
          if (w_acc) begin
            if (in_data == CH_TAG_S)      r_state <= ST_RX_STR;
            else if (in_data == CH_TAG_P) r_state <= ST_RX_PAT;
            else if (!w_is_lf)            r_state <= ST_SKIP;
          end
        end
        ST_RX_STR: begin
          if (w_acc && w_is_lf) begin
            r_str_ok <= !(w_str_ovf || (w_str_cnt == '0));
            r_state  <= ST_TAG;
          end
        end
        ST_RX_PAT: begin
          if (w_acc && w_is_lf) begin
            r_in_ready <= 1'b0;
            if (w_pat_ovf || (w_pat_cnt == '0) || !r_str_ok) begin
              r_res_valid <= 1'b1;
              r_res_err   <= 1'b1;
              r_res_match <= 1'b0;
              r_res_index <= 5'd0;
              r_state     <= ST_RESULT;
            end else begin
              r_state <= ST_EMIT_STR;
            end
          end
        end
        ST_SKIP: begin
          if (w_acc && w_is_lf) r_state <= ST_TAG;
        end
        ST_EMIT_STR: begin
          r_chardata <= w_str_rdata;
          r_isstring <= 1'b1;
          if (w_str_last) r_state <= ST_EMIT_PAT;
        end
        ST_EMIT_PAT: begin
          r_chardata  <= w_pat_rdata;
          r_ispattern <= 1'b1;
          if (w_pat_last) r_state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          r_wdog  <= WD_W'(1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sme_valid) begin
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b0;
            r_res_match <= sme_match;
            r_res_index <= sme_match ? sme_match_index : 5'd0;
            r_state     <= ST_RESULT;
          end else if (r_wdog == WD_W'(WAIT_MAX)) begin
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_res_match <= 1'b0;
            r_res_index <= 5'd0;
            r_state     <= ST_RESULT;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_res_match <= 1'b0;
            r_res_index <= 5'd0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_TAG;
          end
        end
        default: r_state <= ST_TAG;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign chardata  = r_chardata;
  assign isstring  = r_isstring;
  assign ispattern = r_ispattern;
  assign res_valid = r_res_valid;
  assign res_match = r_res_match;
  assign res_index = r_res_index;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_sme_job_feeder.sv
// Bench for sme_job_feeder: vector table, hand-written corner sequences and random lines against a line-level model.
module tb_sme_job_feeder;
  import sme_pkg::*;

  localparam int WAIT_MAX = 1023;
  localparam int STR_MAX  = 32;
  localparam int PAT_MAX  = 10;
  localparam int NV       = 17;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid = 1'b0;
  logic       sme_match = 1'b0;
  logic [4:0] sme_match_index = 5'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;

  always #5 clk = ~clk;

  sme_job_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_index(res_index), .res_err(res_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int launch_cyc = 0;
  logic [7:0] cap_s[$];
  logic [7:0] cap_p[$];
  bit launched = 0;
  bit prev_s = 0;
  bit prev_p = 0;

  typedef struct {
    bit         launch;
    bit         res;
    bit         m;
    logic [4:0] idx;
    bit         err;
    bit         match;
    logic [4:0] ridx;
  } vec_t;

  vec_t  vt[NV];
  string vl[NV], ves[NV], vep[NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SME-side observer: captures the bursts and checks drive rules every cycle.
  always @(negedge clk) begin
    if (isstring) cap_s.push_back(chardata);
    if (ispattern) cap_p.push_back(chardata);
    if (isstring || ispattern) chk("drive_excl_inready", {30'd0, isstring & ispattern, in_ready}, 32'd0);
    if (prev_s && !isstring) chk("str_pat_no_gap", {31'd0, ispattern}, 32'd1);
    if (prev_p && !ispattern && !isstring) begin
      launched = 1;
      launch_cyc = cyc;
      chk("launch_chardata", {24'd0, chardata}, 32'd0);
    end
    prev_s = isstring;
    prev_p = ispattern;
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_line(input string line, input bit exp_launch, input bit exp_res,
                         input bit m, input logic [4:0] idx, input bit e_err, input bit e_match,
                         input logic [4:0] e_idx, input string es, input string ep, input int hold);
    int t;
    bit ok;
    cap_s.delete();
    cap_p.delete();
    launched = 0;
    send_line(line);
    if (exp_launch) begin
      t = 0;
      while (!launched && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("launch_seen", {31'd0, launched}, 32'd1);
      chk("str_burst_len", cap_s.size(), es.len());
      chk("pat_burst_len", cap_p.size(), ep.len());
      ok = (cap_s.size() == es.len()) && (cap_p.size() == ep.len());
      if (ok) begin
        for (int i = 0; i < es.len(); i++) if (cap_s[i] != es[i]) ok = 0;
        for (int i = 0; i < ep.len(); i++) if (cap_p[i] != ep[i]) ok = 0;
      end
      chk("burst_data", {31'd0, ok}, 32'd1);
      sme_match = m;
      sme_match_index = idx;
      sme_valid = 1'b1;
      @(negedge clk);
      sme_valid = 1'b0;
      chk("res_latency", {31'd0, res_valid}, 32'd1);
    end else if (exp_res) begin
      t = 0;
      while (!res_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("res_seen", {31'd0, res_valid}, 32'd1);
      chk("no_sme_drive", cap_s.size() + cap_p.size(), 32'd0);
    end else begin
      repeat (4) @(negedge clk);
      chk("no_result", {31'd0, res_valid}, 32'd0);
      chk("no_sme_drive", cap_s.size() + cap_p.size(), 32'd0);
    end
    if (exp_res) begin
      chk("res_err", {31'd0, res_err}, {31'd0, e_err});
      chk("res_match", {31'd0, res_match}, {31'd0, e_match});
      chk("res_index", {27'd0, res_index}, {27'd0, e_idx});
      ok = 1;
      in_data = CH_TAG_S;
      in_valid = (hold > 0);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!res_valid || res_err !== e_err || res_match !== e_match || res_index !== e_idx || in_ready)
          ok = 0;
      end
      in_valid = 1'b0;
      if (hold > 0) chk("res_hold_stable", {31'd0, ok}, 32'd1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("res_clear", {31'd0, res_valid}, 32'd0);
    end
  endtask

  task automatic set_vec(input int i, input string line, input bit launch, input bit res,
                         input bit m, input logic [4:0] idx, input bit err, input bit match,
                         input logic [4:0] ridx, input string es, input string ep);
    vl[i] = line; ves[i] = es; vep[i] = ep;
    vt[i].launch = launch; vt[i].res = res; vt[i].m = m; vt[i].idx = idx;
    vt[i].err = err; vt[i].match = match; vt[i].ridx = ridx;
  endtask

  function automatic string rnd_body(input int len);
    string s = "";
    logic [7:0] c;
    for (int i = 0; i < len; i++) begin
      c = 8'(97 + $urandom_range(0, 25));
      s = $sformatf("%s%c", s, c);
    end
    return s;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int t;
    int kind, len, hold;
    bit str_ok, good, m;
    logic [4:0] idx;
    string mstr, body;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {13'd0, in_ready, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    set_vec(0,  "Pabc\n", 0, 1, 0, 0, 1, 0, 0, "", "");
    set_vec(1,  "Shello world\n", 0, 0, 0, 0, 0, 0, 0, "", "");
    set_vec(2,  "Pworld\n", 1, 1, 1, 5'd6, 0, 1, 5'd6, "hello world", "world");
    set_vec(3,  "Sabcdefghijklmnopqrstuvwxyz0123456\n", 0, 0, 0, 0, 0, 0, 0, "", "");
    set_vec(4,  "Pa\n", 0, 1, 0, 0, 1, 0, 0, "", "");
    set_vec(5,  "Sab\n", 0, 0, 0, 0, 0, 0, 0, "", "");
    set_vec(6,  "Pb\n", 1, 1, 1, 5'd1, 0, 1, 5'd1, "ab", "b");
    set_vec(7,  "Xjunk\n", 0, 0, 0, 0, 0, 0, 0, "", "");
    set_vec(8,  "Sab\n", 0, 0, 0, 0, 0, 0, 0, "", "");
    set_vec(9,  "P^a$\n", 1, 1, 0, 5'd3, 0, 0, 5'd0, "ab", "^a$");
    set_vec(10, "Sabcdefghijklmnopqrstuvwxyz012345\n", 0, 0, 0, 0, 0, 0, 0, "", "");
    set_vec(11, "P^abcdefgh$\n", 1, 1, 1, 5'd31, 0, 1, 5'd31, "abcdefghijklmnopqrstuvwxyz012345", "^abcdefgh$");
    set_vec(12, "Pabcdefghijk\n", 0, 1, 0, 0, 1, 0, 0, "", "");
    set_vec(13, "P\n", 0, 1, 0, 0, 1, 0, 0, "", "");
    set_vec(14, "S\n", 0, 0, 0, 0, 0, 0, 0, "", "");
    set_vec(15, "Pab\n", 0, 1, 0, 0, 1, 0, 0, "", "");
    set_vec(16, "\n", 0, 0, 0, 0, 0, 0, 0, "", "");

    for (int i = 0; i < NV; i++)
      do_line(vl[i], vt[i].launch, vt[i].res, vt[i].m, vt[i].idx, vt[i].err, vt[i].match,
              vt[i].ridx, ves[i], vep[i], i % 3);

    // sme_valid while idle must not create a result
    sme_match = 1'b1; sme_match_index = 5'd5; sme_valid = 1'b1;
    @(negedge clk);
    sme_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sme_valid_ignored", {31'd0, res_valid}, 32'd0);

    // consumer stalls for 20 cycles
    do_line("Sabc\n", 0, 0, 0, 0, 0, 0, 0, "", "", 0);
    do_line("Pc\n", 1, 1, 1, 5'd2, 0, 1, 5'd2, "abc", "c", 20);

    // SME never answers: watchdog result
    do_line("Sxy\n", 0, 0, 0, 0, 0, 0, 0, "", "", 0);
    cap_s.delete(); cap_p.delete(); launched = 0;
    send_line("Pz\n");
    t = 0;
    while (!launched && t < 200) begin @(negedge clk); t++; end
    chk("wdog_launch_seen", {31'd0, launched}, 32'd1);
    t = 0;
    while (!res_valid && t < WAIT_MAX + 50) begin @(negedge clk); t++; end
    chk("wdog_cycles", cyc - launch_cyc, WAIT_MAX);
    chk("wdog_err", {30'd0, res_err, res_match}, 32'd2);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("wdog_res_clear", {31'd0, res_valid}, 32'd0);

    // reset in the middle of the pattern burst
    do_line("Sabcdefgh\n", 0, 0, 0, 0, 0, 0, 0, "", "", 0);
    send_line("Pabcdefgh\n");
    t = 0;
    while (!ispattern && t < 50) begin @(negedge clk); t++; end
    chk("emit_pat_seen", {31'd0, ispattern}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midjob_reset_outputs", {13'd0, in_ready, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err}, 32'd0);
    @(negedge clk);
    chk("midjob_reset_hold", {13'd0, in_ready, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    do_line("Pab\n", 0, 1, 0, 0, 1, 0, 0, "", "", 0);

    // random lines against a line-level model
    str_ok = 0;
    mstr = "";
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(0, 3);
      if (kind <= 3) begin
        len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : $urandom_range(0, 36);
        body = rnd_body(len);
        str_ok = (len >= 1) && (len <= STR_MAX);
        mstr = body;
        do_line({"S", body, "\n"}, 0, 0, 0, 0, 0, 0, 0, "", "", 0);
      end else if (kind <= 8) begin
        len = $urandom_range(0, 12);
        body = rnd_body(len);
        good = (len >= 1) && (len <= PAT_MAX) && str_ok;
        m = 1'($urandom_range(0, 1));
        idx = 5'($urandom_range(0, 31));
        if (good)
          do_line({"P", body, "\n"}, 1, 1, m, idx, 0, m, m ? idx : 5'd0, mstr, body, hold);
        else
          do_line({"P", body, "\n"}, 0, 1, 0, 0, 1, 0, 0, "", "", hold);
      end else begin
        body = rnd_body($urandom_range(0, 6));
        do_line({"X", body, "\n"}, 0, 0, 0, 0, 0, 0, 0, "", "", 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
